mult_seq_4x4: RTL
=================

# mult_seq_4x4

Sequential 4x4 unsigned multiplier. It latches two 4-bit operands, walks the multiplier operand in two 2-bit slices, and accumulates one shifted 4x2 partial product per cycle into an 8-bit result. Slice selection is done by an instance of `mux_2bit`, with slice 0 on `in_1`, slice 1 on `in_2`, and the step index on `s`. The block is the controller and datapath stage that consumes the `mux_2bit` output and presents the final product to the top level over a done/ack handshake.

## Interface
Parameters:
- none. Operand width is fixed at 4 and slice width at 2.

Ports:
- `clk`, input, 1: the single system clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset is synchronous and active-low.
- `start`, input, 1: request to multiply `a` by `b`. Sampled only in IDLE, or in DONE together with `ack`.
- `a`, input, 4: multiplicand, latched when `start` is accepted.
- `b`, input, 4: multiplier, latched when `start` is accepted.
- `ack`, input, 1: consumer has taken `product`. Sampled only in DONE.
- `busy`, output, 1: high in STEP0 and STEP1.
- `done`, output, 1: high in DONE only.
- `product`, output, 8: result register. Holds its last value until overwritten by the next completion.

## Operation
- The FSM has four states: IDLE, STEP0, STEP1, DONE. Encoding is binary, 2 bits.
- **IDLE:**
  - If `start` is high: `a_r<=a`, `b_r<=b`, `acc<=0`, next state STEP0.
  - Otherwise stay in IDLE.
- **STEP0:**
  - `mux_2bit` select = 0, so slice = `b_r[1:0]`.
  - `acc <= acc + pp`, with `pp` zero-extended to 8 bits.
  - Next state STEP1.
- **STEP1:**
  - Select = 1, so slice = `b_r[3:2]`.
  - `acc <= acc + (pp << 2)`.
  - `product <= acc + (pp << 2)`.
  - Next state DONE.
- **Partial product:** `pp = (slice[0] ? a_r : 0) + (slice[1] ? a_r<<1 : 0)`.
  - Width is 6 bits, range 0..45.
  - `acc` is 8 bits and cannot overflow, since the maximum is 15*15 = 225.
- **DONE:**
  - `ack` low: hold in DONE.
  - `ack` high and `start` low: go to IDLE.
  - `ack` high and `start` high: back-to-back. Latch new `a`/`b`, clear `acc`, go to STEP0.
- `start` in STEP0 or STEP1 is ignored. Operands and accumulator are unaffected.
- Changes on `a` or `b` after acceptance have no effect.
- `ack` outside DONE is ignored.
- The mux select is driven from the state: 0 in STEP0, 1 in STEP1, and 0 in every other state.

## Timing
- **Reset:** `rst_n` low at a rising edge gives state = IDLE and `a_r`, `b_r`, `acc`, `product` = 0. Therefore `busy` = 0, `done` = 0, `product` = 8'h00.
- Reset takes effect in any state, including mid-multiply. The partial result is discarded and no `done` is produced.
- **Latency:** with `start` accepted at edge k:
  - STEP0 is active in cycle k..k+1.
  - STEP1 is active in cycle k+1..k+2.
  - `done` and a valid `product` are visible after edge k+2. That is 3 edges from acceptance to DONE.
- **Handshake:**
  - `done` stays high until the edge where `ack` is sampled high.
  - `done` falls after that edge, unless back-to-back, in which case `busy` rises instead.
- **Throughput:** one result per 3 cycles with back-to-back start+ack. The minimum is 4 cycles when returning through IDLE.
- `product` changes only on the STEP1-to-DONE edge and on reset.

## Structure
- Package `mult_pkg` holds:
  - state encodings `S_IDLE=2'd0`, `S_STEP0=2'd1`, `S_STEP1=2'd2`, `S_DONE=2'd3`;
  - `OP_W=4`, `SLICE_W=2`, `PROD_W=8`.
- Sub-module `pp_4x2` is the combinational 4-bit by 2-bit partial-product generator with a 6-bit output. It is a natural separation from the FSM and accumulator.
- The existing `mux_2bit` is instantiated for slice selection. Bit-select indexing of `b_r` directly is not used in its place.

## Test plan
- **Basic multiply:** reset, then `a`=7, `b`=6, `start` for 1 cycle.
  - `busy` is high for 2 cycles.
  - Then `done`=1 and `product`=8'h2A (42): slice0 gives 14 and slice1 gives 28.
  - `ack` then gives IDLE and `done`=0.
- **Max and zero:**
  - `a`=15, `b`=15 gives `product`=8'hE1 (225).
  - `a`=9, `b`=0 gives `product`=8'h00.
  - `a`=0, `b`=15 gives `product`=8'h00.
- **Ignored inputs during busy:** `a`=5, `b`=3, `start`. In STEP0 drive `start`=1, `a`=15, `b`=15.
  - Result is `product`=8'h0F (15).
  - No restart occurs, and `done` appears exactly 3 edges after the first acceptance.
- **Hold and back-to-back:**
  - Hold `ack`=0 for 5 cycles: `done` and `product` stay stable.
  - Then `ack`=1 and `start`=1 with `a`=3, `b`=4 in the same cycle.
  - Expect immediate STEP0 and, 3 edges later, `product`=8'h0C (12).
- **Reset mid-operation:** `start` with `a`=11, `b`=13, then `rst_n`=0 during STEP1.
  - After the edge: `busy`=0, `done`=0, `product`=0.
  - No `done` pulse follows. A subsequent 11*13 gives 8'h8F (143).

Source files
------------

// File: rtl/mult_pkg.sv
// Shared widths and FSM state encoding for the sequential 4x4 multiplier.
package mult_pkg;
   localparam int OP_W    = 4;
   localparam int SLICE_W = 2;
   localparam int PROD_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STEP0 = 2'd1,
      S_STEP1 = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/mux_2bit.sv
// Two-input, 2-bit wide selector: s=0 picks in_1, s=1 picks in_2.
module mux_2bit (
   input  logic [1:0] in_1,
   input  logic [1:0] in_2,
   input  logic       s,
   output logic [1:0] out
);
   assign out = s ? in_2 : in_1;
endmodule

// File: rtl/pp_4x2.sv
// Combinational 4-bit x 2-bit partial product, 6-bit result (0..45).
module pp_4x2
   import mult_pkg::*;
(
   input  logic [OP_W-1:0]    a,
   input  logic [SLICE_W-1:0] slice,
   output logic [5:0]         pp
);
   logic [5:0] term0;
   logic [5:0] term1;

   assign term0 = slice[0] ? {2'b00, a}       : 6'd0;
   assign term1 = slice[1] ? {1'b0, a, 1'b0}  : 6'd0;
   assign pp    = term0 + term1;
endmodule

// File: rtl/mult_seq_4x4.sv
// Sequential 4x4 unsigned multiplier: two 2-bit multiplier slices, one per cycle,
// accumulated into an 8-bit product presented over a done/ack handshake.
module mult_seq_4x4
   import mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   input  logic              ack,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);
   // Handshake: done is high while a result waits; the result is consumed on the
   // edge where ack is sampled high in DONE. start is honoured only in IDLE, or in
   // DONE together with ack (back-to-back); elsewhere start and ack are ignored.

   state_t              state_q, state_d;
   logic [OP_W-1:0]     a_r, b_r;
   logic [PROD_W-1:0]   acc;
   logic                load;
   logic                sel;
   logic [SLICE_W-1:0]  slice;
   logic [5:0]          pp;
   logic [PROD_W-1:0]   pp_ext;
   logic [PROD_W-1:0]   sum_lo;
   logic [PROD_W-1:0]   sum_hi;

   assign sel = (state_q == S_STEP1);

   mux_2bit u_mux (
      .in_1 (b_r[1:0]),
      .in_2 (b_r[3:2]),
      .s    (sel),
      .out  (slice)
   );

   pp_4x2 u_pp (
      .a     (a_r),
      .slice (slice),
      .pp    (pp)
   );

   assign pp_ext = {2'b00, pp};
   assign sum_lo = acc + pp_ext;
   // Upper slice carries weight 4; max 45*4 = 180 still fits in 8 bits.
   assign sum_hi = acc + (pp_ext << 2);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = S_STEP0;
            end
         end
         S_STEP0: state_d = S_STEP1;
         S_STEP1: state_d = S_DONE;
         S_DONE: begin
            if (ack) begin
               if (start) begin
                  load    = 1'b1;
                  state_d = S_STEP0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_r     <= '0;
         b_r     <= '0;
         acc     <= '0;
         product <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
         end else if (state_q == S_STEP0) begin
            acc <= sum_lo;
         end else if (state_q == S_STEP1) begin
            acc     <= sum_hi;
            product <= sum_hi;
         end
      end
   end

   assign busy = (state_q == S_STEP0) || (state_q == S_STEP1);
   assign done = (state_q == S_DONE);
endmodule
